// File: rtl/gate_check_sequencer.sv
// Drives a deterministic run of test vectors into a bank of buf/not gate lanes
// and scores the sampled outputs, reporting pass/fail counts and the first failure.
module gate_check_sequencer #(
    parameter int          WIDTH       = 8,
    parameter int          NUM_VECTORS = 10,
    parameter int          SETTLE      = 1,
    parameter logic [15:0] SEED        = 16'hACE1,
    localparam int         CW          = $clog2(NUM_VECTORS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [WIDTH-1:0] drv_a,
    input  logic [WIDTH-1:0] obs_c,
    input  logic [WIDTH-1:0] obs_d,
    output logic             busy,
    output logic             done,
    output logic [CW-1:0]    pass_cnt,
    output logic [CW-1:0]    fail_cnt,
    output logic             fail_seen,
    output logic [CW-1:0]    first_fail_idx
);

    localparam int WW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    state_t        state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [CW-1:0] idx;
    logic [WW-1:0] wait_cnt;
    logic          vec_ok;
    logic          last_vec;
    logic          last_wait;

    assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    // Exact-match compare so an undriven or unknown lane fails the vector.
    assign vec_ok    = (obs_c === drv_a) && (obs_d === ~drv_a);
    assign last_vec  = (idx == CW'(NUM_VECTORS - 1));
    assign last_wait = (wait_cnt == WW'(SETTLE - 1));

    // start is a level sampled each edge and only acted on in S_IDLE; abort is
    // sampled every edge and always wins over start.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            lfsr           <= SEED;
            drv_a          <= '0;
            idx            <= '0;
            wait_cnt       <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            pass_cnt       <= '0;
            fail_cnt       <= '0;
            fail_seen      <= 1'b0;
            first_fail_idx <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (abort) begin
                        done <= 1'b0;
                    end else if (start) begin
                        lfsr           <= SEED;
                        drv_a          <= '0;
                        idx            <= '0;
                        wait_cnt       <= '0;
                        pass_cnt       <= '0;
                        fail_cnt       <= '0;
                        fail_seen      <= 1'b0;
                        first_fail_idx <= '0;
                        done           <= 1'b0;
                        busy           <= 1'b1;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + WW'(1);
                        if (last_wait) begin
                            state <= S_CHECK;
                        end
                    end
                end
                S_CHECK: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (vec_ok) begin
                            pass_cnt <= pass_cnt + CW'(1);
                        end else begin
                            fail_cnt <= fail_cnt + CW'(1);
                            if (!fail_seen) begin
                                fail_seen      <= 1'b1;
                                first_fail_idx <= idx;
                            end
                        end
                        if (last_vec) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= S_IDLE;
                        end else begin
                            lfsr     <= lfsr_next;
                            drv_a    <= lfsr_next[WIDTH-1:0];
                            idx      <= idx + CW'(1);
                            wait_cnt <= '0;
                            state    <= S_WAIT;
                        end
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_check_sequencer.sv
// Bench for gate_check_sequencer: a faultable gate-bank model feeds the DUT and
// every observed output is compared with a vector-level reference model.
module tb_gate_check_sequencer;

    localparam int NV    = 10;
    localparam int ST    = 1;
    localparam int TOTAL = NV * (ST + 1);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [7:0] drv_a, obs_c, obs_d;
    logic       busy, done, fail_seen;
    logic [3:0] pass_cnt, fail_cnt, first_fail_idx;

    logic       start2 = 1'b0;
    logic [7:0] drv_a2, obs_c2, obs_d2;
    logic       busy2, done2, fail_seen2;
    logic [1:0] pass_cnt2, fail_cnt2, first_fail_idx2;

    // Gate-bank fault model: masked lanes are stuck at the given value.
    logic [7:0] c_mask = '0, c_val = '0, d_mask = '0, d_val = '0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    assign obs_c  = (drv_a & ~c_mask) | (c_val & c_mask);
    assign obs_d  = (~drv_a & ~d_mask) | (d_val & d_mask);
    assign obs_c2 = (drv_a2 & ~c_mask) | (c_val & c_mask);
    assign obs_d2 = (~drv_a2 & ~d_mask) | (d_val & d_mask);

    gate_check_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .drv_a(drv_a), .obs_c(obs_c), .obs_d(obs_d),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .fail_seen(fail_seen), .first_fail_idx(first_fail_idx)
    );

    gate_check_sequencer #(.WIDTH(8), .NUM_VECTORS(2), .SETTLE(3), .SEED(16'hACE1)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .abort(1'b0),
        .drv_a(drv_a2), .obs_c(obs_c2), .obs_d(obs_d2),
        .busy(busy2), .done(done2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2),
        .fail_seen(fail_seen2), .first_fail_idx(first_fail_idx2)
    );

    // Vector k of a run: 0 for k=0, otherwise the low byte after k LFSR steps.
    function automatic logic [7:0] vec(input int k);
        logic [15:0] l;
        l = 16'hACE1;
        if (k == 0) return 8'h00;
        for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l[7:0];
    endfunction

    function automatic bit vec_fails(input int k);
        logic [7:0] a;
        a = vec(k);
        return (((a ^ c_val) & c_mask) != 0) || (((~a ^ d_val) & d_mask) != 0);
    endfunction

    // Expected score after the first n vectors have been checked.
    task automatic model_score(input int n, output int p, output int f, output bit seen,
                               output int ffi);
        p = 0; f = 0; seen = 0; ffi = 0;
        for (int k = 0; k < n; k++) begin
            if (vec_fails(k)) begin
                f++;
                if (!seen) begin
                    seen = 1;
                    ffi  = k;
                end
            end else begin
                p++;
            end
        end
    endtask

    task automatic check_score(input string name, input int n);
        int p, f, ffi;
        bit seen;
        model_score(n, p, f, seen, ffi);
        checks++;
        if (pass_cnt !== 4'(p) || fail_cnt !== 4'(f) || fail_seen !== seen ||
            (seen && first_fail_idx !== 4'(ffi))) begin
            errors++;
            $display("FAIL %s score n=%0d got p=%0d f=%0d seen=%0b ffi=%0d exp p=%0d f=%0d seen=%0b ffi=%0d",
                     name, n, pass_cnt, fail_cnt, fail_seen, first_fail_idx, p, f, seen, ffi);
        end
    endtask

    task automatic start_run();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // One run of dut; restart_at/abort_at/rst_at are cycle offsets from the
    // first busy cycle (-1 disables). Every in-run cycle is checked.
    task automatic run_scenario(input string name, input int restart_at, input int abort_at,
                                input int rst_at);
        int cyc, end_at, n;
        end_at = (abort_at >= 0) ? abort_at : ((rst_at >= 0) ? rst_at : TOTAL);
        start_run();
        cyc = 0;
        while (cyc < end_at) begin
            checks++;
            if (drv_a !== vec(cyc / (ST + 1)) || busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s run cyc=%0d got drv_a=%h busy=%0b done=%0b exp drv_a=%h busy=1 done=0",
                         name, cyc, drv_a, busy, done, vec(cyc / (ST + 1)));
            end
            check_score(name, cyc / (ST + 1));
            start = (cyc == restart_at);
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        if (abort_at >= 0) begin
            abort = 1'b1;
            @(posedge clk); #1 abort = 1'b0;
            n = abort_at / (ST + 1);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || drv_a !== vec(n)) begin
                errors++;
                $display("FAIL %s abort got busy=%0b done=%0b drv_a=%h exp busy=0 done=0 drv_a=%h",
                         name, busy, done, drv_a, vec(n));
            end
            check_score({name, "_abort"}, n);
        end else if (rst_at >= 0) begin
            rst = 1'b1;
            @(posedge clk); #1 rst = 1'b0;
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || drv_a !== 8'h00 || pass_cnt !== 4'd0 ||
                fail_cnt !== 4'd0 || fail_seen !== 1'b0 || first_fail_idx !== 4'd0) begin
                errors++;
                $display("FAIL %s rst got busy=%0b done=%0b drv_a=%h p=%0d f=%0d seen=%0b ffi=%0d exp all 0",
                         name, busy, done, drv_a, pass_cnt, fail_cnt, fail_seen, first_fail_idx);
            end
        end else begin
            checks++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                errors++;
                $display("FAIL %s end cyc=%0d got done=%0b busy=%0b exp done=1 busy=0",
                         name, cyc, done, busy);
            end
            check_score({name, "_end"}, NV);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || drv_a !== 8'h00 || pass_cnt !== 4'd0 ||
            fail_cnt !== 4'd0 || fail_seen !== 1'b0 || first_fail_idx !== 4'd0 || busy2 !== 1'b0) begin
            errors++;
            $display("FAIL reset got busy=%0b done=%0b drv_a=%h p=%0d f=%0d seen=%0b ffi=%0d exp all 0",
                     busy, done, drv_a, pass_cnt, fail_cnt, fail_seen, first_fail_idx);
        end
    endtask

    task automatic test_ideal();
        c_mask = '0; d_mask = '0;
        run_scenario("ideal", -1, -1, -1);
    endtask

    task automatic test_stuck_d3();
        c_mask = '0; d_mask = 8'h08; d_val = 8'h08;
        run_scenario("stuck_d3", -1, -1, -1);
        d_mask = '0;
    endtask

    task automatic test_settle3();
        int cyc;
        c_mask = '0; d_mask = '0;
        @(posedge clk); #1 start2 = 1'b1;
        @(posedge clk); #1 start2 = 1'b0;
        for (cyc = 0; cyc < 8; cyc++) begin
            checks++;
            if (drv_a2 !== vec(cyc / 4) || busy2 !== 1'b1 || done2 !== 1'b0) begin
                errors++;
                $display("FAIL settle3 cyc=%0d got drv_a=%h busy=%0b done=%0b exp drv_a=%h busy=1 done=0",
                         cyc, drv_a2, busy2, done2, vec(cyc / 4));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || pass_cnt2 !== 2'd2 || fail_cnt2 !== 2'd0) begin
            errors++;
            $display("FAIL settle3_end got done=%0b busy=%0b p=%0d f=%0d exp done=1 busy=0 p=2 f=0",
                     done2, busy2, pass_cnt2, fail_cnt2);
        end
    endtask

    task automatic test_restart_midrun();
        run_scenario("restart", 5, -1, -1);
    endtask

    task automatic test_rst_midrun();
        run_scenario("rst_mid", -1, -1, 4 * (ST + 1));
    endtask

    task automatic test_abort_then_start();
        run_scenario("abort5", -1, 4, -1);
        run_scenario("after_abort", -1, -1, -1);
    endtask

    task automatic test_start_abort_idle();
        logic [3:0] p_before;
        p_before = pass_cnt;
        @(posedge clk); #1 begin start = 1'b1; abort = 1'b1; end
        @(posedge clk); #1 begin start = 1'b0; abort = 1'b0; end
        repeat (3) begin
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || pass_cnt !== p_before) begin
                errors++;
                $display("FAIL start_abort got busy=%0b done=%0b p=%0d exp busy=0 done=0 p=%0d",
                         busy, done, pass_cnt, p_before);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        int ab, rs;
        for (int r = 0; r < 12; r++) begin
            c_mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            c_val  = 8'($urandom_range(0, 255));
            d_mask = 8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255));
            d_val  = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 3) == 0) begin c_mask = '0; d_mask = '0; end
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, TOTAL - 1)) : -1;
            rs = ($urandom_range(0, 1) == 0) ? int'($urandom_range(1, TOTAL - 2)) : -1;
            run_scenario("random", rs, ab, -1);
        end
        c_mask = '0; d_mask = '0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_stuck_d3();
        test_settle3();
        test_restart_midrun();
        test_rst_midrun();
        test_abort_then_start();
        test_ideal();
        test_start_abort_idle();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_check_sequencer.md
Name: gate_check_sequencer

Overview:
- Self-checking stimulus controller for a bank of WIDTH parallel buf/not gate lanes. Each lane has input a, buffered output c and inverted output d.
- Sequences a run of NUM_VECTORS input vectors: vector 0 is all-zero, later vectors come from an internal 16-bit LFSR. Each vector is held for SETTLE cycles, then both gate outputs are sampled and compared against a.
- Sits between the gate bank and test/status logic. Replaces free-running random drive with a deterministic, countable, restartable sequence.

Parameters:
- WIDTH, 8, number of gate lanes; width of drv_a, obs_c and obs_d; 1..16.
- NUM_VECTORS, 10, vectors per run; at least 1.
- SETTLE, 1, cycles each vector is held before sampling; at least 1.
- SEED, 16'hACE1, LFSR value loaded on reset and on every start; must be non-zero.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begins a run; honoured only in IDLE.
- abort  input  1  synchronous abort; returns the block to IDLE.
- drv_a  output  WIDTH  input vector driven to every lane's a.
- obs_c  input  WIDTH  buf outputs from the gate bank.
- obs_d  input  WIDTH  not outputs from the gate bank.
- busy  output  1  high while in WAIT or CHECK.
- done  output  1  high once a run completes; stays high until the next start, abort or rst.
- pass_cnt  output  CW  vectors that passed; CW = $clog2(NUM_VECTORS+1).
- fail_cnt  output  CW  vectors that failed.
- fail_seen  output  1  sticky; set on the first failing vector of a run.
- first_fail_idx  output  CW  index of the first failing vector; valid only when fail_seen=1.

Behaviour:
- Reset (rst=1 at a clock edge; overrides everything, including mid-run):
  - state=IDLE, lfsr=SEED, drv_a=0, idx=0, wait_cnt=0.
  - busy=0, done=0, pass_cnt=0, fail_cnt=0, fail_seen=0, first_fail_idx=0.
- LFSR: 16-bit Galois, right shift. next = lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1.
- States:
  - IDLE:
    - On start=1 and abort=0: lfsr<=SEED, drv_a<=0, idx<=0, wait_cnt<=0, clear pass_cnt, fail_cnt, fail_seen, first_fail_idx and done; go to WAIT.
    - If start and abort are both high, abort wins and no run begins.
  - WAIT:
    - wait_cnt increments each cycle.
    - When wait_cnt==SETTLE-1, go to CHECK, so WAIT lasts exactly SETTLE cycles. drv_a is stable throughout.
  - CHECK (exactly 1 cycle):
    - Vector passes iff obs_c===drv_a and obs_d===~drv_a across all lanes. Any X/Z or any single-lane mismatch fails the whole vector.
    - Pass increments pass_cnt. Fail increments fail_cnt; if fail_seen=0, set fail_seen and first_fail_idx<=idx.
    - If idx==NUM_VECTORS-1: done<=1, go to IDLE.
    - Otherwise: lfsr<=next, drv_a<=next[WIDTH-1:0], idx<=idx+1, wait_cnt<=0, go to WAIT.
- busy=1 exactly in WAIT and CHECK. A run occupies NUM_VECTORS*(SETTLE+1) cycles. done rises on the edge that ends the last CHECK.
- start while busy is ignored; no restart and no counter change.
- abort=1 in WAIT or CHECK:
  - Next state is IDLE; done stays 0.
  - Counters and fail fields keep their values, excluding the CHECK aborted in that cycle, which is not scored.
  - drv_a holds its last value.
- pass_cnt+fail_cnt equals the number of completed CHECKs; it is NUM_VECTORS after a full run.
- All outputs are registered; there is no combinational path from obs_* to any output.

Test Plan:
- Ideal gate model (c=a, d=~a), defaults, one start pulse:
  - drv_a sequence begins 8'h00, 8'h70; busy high for 20 cycles.
  - Then done=1, pass_cnt=10, fail_cnt=0, fail_seen=0.
- Gate model with obs_d[3] stuck at 1, defaults:
  - Vector 0 (a=0) does not fail on d[3]; vector 1 (a=8'h70, a[3]=0) does not fail either.
  - first_fail_idx equals the first index whose drv_a[3]=1.
  - fail_cnt equals the number of vectors with a[3]=1.
- SETTLE=3, NUM_VECTORS=2: each drv_a is held 3 cycles before its CHECK; done rises 8 cycles after start is sampled.
- Timing and reset interactions:
  - start re-pulsed mid-run: counters unchanged, run finishes on schedule.
  - rst asserted during WAIT of vector 4: next cycle all outputs are at reset values and drv_a=0.
- Abort interactions:
  - abort in cycle 5 of a run: IDLE next cycle, done=0, pass_cnt=2 (vectors 0–1), drv_a unchanged.
  - A following start clears all counters and replays 8'h00, 8'h70.
  - start and abort high together in IDLE: no run begins, busy stays 0.
